// File: rtl/reg_file_param.sv
// Clocked multi-port register file with registered reads, optional hardwired zero entry and a post-reset clearing sweep.
// Define REGFILE_BYPASS_EN for write-first same-edge read/write behaviour; undefined gives read-first.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_register,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_register,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     init_busy
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADDR_W:0]   sweep_cnt_reg;
  logic              init_busy_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // A write to entry 0 is silently dropped when the zero register is hardwired.
  always_comb begin
    wr_accept = 1'b0;
    if (state_reg == READY && reg_write) begin
      wr_accept = 1'b1;
      if (ZERO_REG != 0 && write_register == '0) begin
        wr_accept = 1'b0;
      end
    end
  end

  // The sweep owns the single write port while INIT; user writes only in READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_register;
    mem_wdata = write_data;
    if (state_reg == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_cnt_reg[ADDR_W-1:0];
      mem_wdata = '0;
    end else if (wr_accept) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= INIT;
      sweep_cnt_reg <= '0;
      init_busy_reg <= 1'b1;
    end else begin
      case (state_reg)
        INIT: begin
          sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
          if (sweep_cnt_reg == LAST_IDX) begin
            state_reg     <= READY;
            init_busy_reg <= 1'b0;
          end
        end
        READY: begin
          init_busy_reg <= 1'b0;
        end
        default: begin
          state_reg     <= INIT;
          sweep_cnt_reg <= '0;
          init_busy_reg <= 1'b1;
        end
      endcase
    end
  end

  assign init_busy = init_busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0] rd_next;
      logic [DATA_W-1:0] rdata_reg;

      assign rd_addr = read_register[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd_next = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && write_register == rd_addr) begin
          rd_next = write_data;
        end
`endif
        if (ZERO_REG != 0 && rd_addr == '0) begin
          rd_next = '0;
        end
      end

      // Output stays at zero until the sweep has finished clearing the array.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_reg <= '0;
        end else if (state_reg == READY) begin
          rdata_reg <= rd_next;
        end else begin
          rdata_reg <= '0;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rdata_reg;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param (4 read ports, zero register on); expected read data is queued at issue
// and checked by a monitor one cycle later. Hazard expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     reg_write = 1'b0;
  logic [ADDR_W-1:0]        write_register = '0;
  logic [DATA_W-1:0]        write_data = '0;
  logic [NUM_RD*ADDR_W-1:0] read_register = '0;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     init_busy;

  reg_file_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_write     (reg_write),
    .write_register(write_register),
    .write_data    (write_data),
    .read_register (read_register),
    .rdata         (rdata),
    .init_busy     (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                      tag;
    logic [3:0][DATA_W-1:0]  d;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Read data appears on the edge that samples the addresses; flag it for the monitor.
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        for (int k = 0; k < NUM_RD; k++) begin
          chk($sformatf("t%0d_port%0d", e.tag, k), rdata[k*DATA_W +: DATA_W], e.d[k]);
        end
      end
    end
  end

  // One clock of stimulus: optional write plus optional 4-port read with expected data.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rd, input int tag,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    exp_t e;
    reg_write      = we;
    write_register = wa;
    write_data     = wd;
    read_register  = {a3, a2, a1, a0};
    rd_req         = rd;
    if (rd) begin
      e.tag  = tag;
      e.d[0] = e0;
      e.d[1] = e1;
      e.d[2] = e2;
      e.d[3] = e3;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    rd_req    = 1'b0;
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b1, wa, wd, 1'b0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic rd4(input int tag, input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    step(1'b0, 5'd0, 32'd0, 1'b1, tag, a0, a1, a2, a3, e0, e1, e2, e3);
  endtask

  // Counts edges until init_busy drops, bounded so a stuck sweep still ends the run.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!init_busy) break;
    end
    chk(name, 32'(n), 32'd32);
  endtask

  logic [31:0] hazard_exp;

  initial begin
`ifdef REGFILE_BYPASS_EN
    hazard_exp = 32'h0000_0069;
`else
    hazard_exp = 32'h0000_001A;
`endif
    #1;
    reset = 1'b1;
    #2;
    chk("por_rdata0", rdata[31:0], 32'd0);
    chk("por_rdata3", rdata[127:96], 32'd0);
    chk("por_busy", 32'(init_busy), 32'd1);

    // Hold a write to r4 and reads of r4 for the whole sweep: both must be ignored.
    reg_write      = 1'b1;
    write_register = 5'd4;
    write_data     = 32'hFFFF_FFFF;
    read_register  = {4{5'd4}};
    #9;
    reset = 1'b0;
    wait_init("sweep_len_1");
    reg_write = 1'b0;
    chk("init_rdata_held", rdata[31:0], 32'd0);

    rd4(1, 5'd4, 5'd0, 5'd31, 5'd4, 32'd0, 32'd0, 32'd0, 32'd0);

    wr(5'd3, 32'h0000_0052);
    rd4(2, 5'd3, 5'd3, 5'd0, 5'd4, 32'h52, 32'h52, 32'd0, 32'd0);

    wr(5'd0, 32'h0000_00E9);
    rd4(3, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    wr(5'd7, 32'h0000_001A);
    step(1'b1, 5'd7, 32'h0000_0069, 1'b1, 4, 5'd7, 5'd7, 5'd3, 5'd0,
         hazard_exp, hazard_exp, 32'h52, 32'd0);
    rd4(5, 5'd7, 5'd3, 5'd7, 5'd0, 32'h69, 32'h52, 32'h69, 32'd0);
    step(1'b1, 5'd0, 32'h0000_0077, 1'b1, 6, 5'd0, 5'd7, 5'd0, 5'd3,
         32'd0, 32'h69, 32'd0, 32'h52);

    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'hC0DE_0000 + 32'(i));
    end
    rd4(7, 5'd1, 5'd15, 5'd30, 5'd31, 32'hC0DE_0001, 32'hC0DE_000F, 32'hC0DE_001E, 32'hC0DE_001F);
    rd4(8, 5'd2, 5'd17, 5'd0, 5'd16, 32'hC0DE_0002, 32'hC0DE_0011, 32'd0, 32'hC0DE_0010);
    idle();

    // Mid-cycle reset in READY with a write pending; everything must clear.
    #2;
    reset          = 1'b1;
    reg_write      = 1'b1;
    write_register = 5'd5;
    write_data     = 32'hDEAD_BEEF;
    #1;
    chk("rst_rdata0", rdata[31:0], 32'd0);
    chk("rst_rdata1", rdata[63:32], 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    #4;
    reset     = 1'b0;
    reg_write = 1'b0;
    wait_init("sweep_len_2");

    for (int b = 0; b < 8; b++) begin
      rd4(10 + b, 5'(4*b), 5'(4*b+1), 5'(4*b+2), 5'(4*b+3), 32'd0, 32'd0, 32'd0, 32'd0);
    end

    wr(5'd9, 32'h1234_5678);
    rd4(20, 5'd9, 5'd31, 5'd9, 5'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0);

    idle();
    idle();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
